// File: rtl/ws2812_pixel_decoder_pkg.sv
// Shared types and default timing for the WS2812-style pixel decoder.
// All cycle counts assume the 50 MHz system clock.
package ws2812_pkg;

    localparam int CLK_HZ             = 50_000_000;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_T_MIN_HIGH     = 5;
    localparam int DEF_T_BIT_THRESH   = 25;
    localparam int DEF_T_MAX_HIGH     = 50;
    // 50 us of low line latches a frame
    localparam int DEF_T_RESET        = CLK_HZ / 20_000;
    localparam int DEF_BITS_PER_PIXEL = 24;
    localparam int PIX_CNT_W          = 16;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        HIGH,
        LOW
    } dec_state_t;

endpackage

// File: rtl/ws2812_pixel_decoder_if.sv
// Serial line in, decoded pixels and frame events out.
// The slave side is the decoder; the master side drives DI and consumes results.
interface ws2812_pixel_decoder_if;
    import ws2812_pkg::*;

    logic                 DI;
    grb_t                 pixel_data;
    logic                 pixel_valid;
    logic                 latch;
    logic [PIX_CNT_W-1:0] frame_pixels;
    logic                 err;
    logic                 busy;

    modport master (
        output DI,
        input  pixel_data,
        input  pixel_valid,
        input  latch,
        input  frame_pixels,
        input  err,
        input  busy
    );

    modport slave (
        input  DI,
        output pixel_data,
        output pixel_valid,
        output latch,
        output frame_pixels,
        output err,
        output busy
    );

endinterface

// File: rtl/ws2812_pixel_decoder_input_sync.sv
// Brings the asynchronous DI pin into the clock domain and flags its edges.
// Edges compare the synchronized level against its one-cycle-old copy.
module ws2812_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic di_i,
    output logic di_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   diPrev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            diPrev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], di_i};
            diPrev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign di_s_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~diPrev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & diPrev_q;

endmodule

// File: rtl/ws2812_pixel_decoder.sv
// Decodes pulse-width-coded pixel bits into 24-bit GRB pixels and frame latches.
// Nothing is decoded until a full reset-length low gap has been seen.
module ws2812_pixel_decoder
    import ws2812_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int T_MIN_HIGH     = DEF_T_MIN_HIGH,
    parameter int T_BIT_THRESH   = DEF_T_BIT_THRESH,
    parameter int T_MAX_HIGH     = DEF_T_MAX_HIGH,
    parameter int T_RESET        = DEF_T_RESET,
    parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ws2812_pixel_decoder_if.slave  bus
);

    localparam int HW = $clog2(T_MAX_HIGH + 1);
    localparam int LW = $clog2(T_RESET + 1);
    localparam int BW = $clog2(BITS_PER_PIXEL + 1);

    localparam logic [HW-1:0] HI_MIN   = HW'(T_MIN_HIGH);
    localparam logic [HW-1:0] HI_THR   = HW'(T_BIT_THRESH);
    localparam logic [HW-1:0] HI_MAX   = HW'(T_MAX_HIGH);
    localparam logic [LW-1:0] LO_MAX   = LW'(T_RESET);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PIXEL - 1);

    logic                      diSync;
    logic                      diRise;
    logic                      diFall;

    dec_state_t                state_q;
    logic [HW-1:0]             hiCnt_q, hiCnt_d;
    logic [LW-1:0]             loCnt_q, loCnt_d;
    logic [BW-1:0]             bitCnt_q;
    logic [PIX_CNT_W-1:0]      pixCnt_q;
    logic [PIX_CNT_W-1:0]      framePixels_q;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    grb_t                      pixelData_q;
    logic                      pixelValid_q;
    logic                      latch_q;
    logic                      err_q;

    ws2812_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .di_i   (bus.DI),
        .di_s_o (diSync),
        .rise_o (diRise),
        .fall_o (diFall)
    );

    // Run-length counters saturate so a long level keeps its terminal value.
    always_comb begin
        hiCnt_d = '0;
        loCnt_d = '0;
        if (diSync) begin
            hiCnt_d = (hiCnt_q == HI_MAX) ? HI_MAX : hiCnt_q + 1'b1;
        end else begin
            loCnt_d = (loCnt_q == LO_MAX) ? LO_MAX : loCnt_q + 1'b1;
        end
        shift_d = {shift_q[BITS_PER_PIXEL-2:0], (hiCnt_q >= HI_THR)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARM;
            hiCnt_q       <= '0;
            loCnt_q       <= '0;
            bitCnt_q      <= '0;
            pixCnt_q      <= '0;
            framePixels_q <= '0;
            shift_q       <= '0;
            pixelData_q   <= '0;
            pixelValid_q  <= 1'b0;
            latch_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hiCnt_q      <= hiCnt_d;
            loCnt_q      <= loCnt_d;
            pixelValid_q <= 1'b0;
            latch_q      <= 1'b0;
            err_q        <= 1'b0;

            unique case (state_q)
                ARM: begin
                    if (loCnt_q == LO_MAX) begin
                        state_q <= diRise ? HIGH : IDLE;
                    end
                end

                IDLE: begin
                    if (diRise) begin
                        state_q <= HIGH;
                    end
                end

                HIGH: begin
                    // A stuck line abandons the whole frame and waits for a clean gap.
                    if (hiCnt_q == HI_MAX) begin
                        err_q    <= 1'b1;
                        bitCnt_q <= '0;
                        pixCnt_q <= '0;
                        state_q  <= ARM;
                    end else if (diFall) begin
                        if (hiCnt_q < HI_MIN) begin
                            err_q <= 1'b1;
                        end else begin
                            shift_q <= shift_d;
                            if (bitCnt_q == BIT_LAST) begin
                                pixelData_q  <= grb_t'(shift_d);
                                pixelValid_q <= 1'b1;
                                bitCnt_q     <= '0;
                                if (pixCnt_q != '1) begin
                                    pixCnt_q <= pixCnt_q + 1'b1;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                            end
                        end
                        state_q <= LOW;
                    end
                end

                LOW: begin
                    if (loCnt_q == LO_MAX) begin
                        latch_q       <= 1'b1;
                        framePixels_q <= pixCnt_q;
                        pixCnt_q      <= '0;
                        bitCnt_q      <= '0;
                        err_q         <= (bitCnt_q != '0);
                        state_q       <= diRise ? HIGH : IDLE;
                    end else if (diRise) begin
                        state_q <= HIGH;
                    end
                end

                default: state_q <= ARM;
            endcase
        end
    end

    assign bus.pixel_data   = pixelData_q;
    assign bus.pixel_valid  = pixelValid_q;
    assign bus.latch        = latch_q;
    assign bus.frame_pixels = framePixels_q;
    assign bus.err          = err_q;
    assign bus.busy         = ((state_q == HIGH) || (state_q == LOW)) && (bitCnt_q != '0);

endmodule

// File: tb/tb_ws2812_pixel_decoder.sv
// Directed bench for the pixel decoder: drives pulse trains on DI and checks
// decoded pixels, latches and error pulses against hand-computed values.
module tb_ws2812_pixel_decoder;

    logic clk;
    logic rst_n;

    ws2812_pixel_decoder_if bus ();

    ws2812_pixel_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          validCnt    = 0;
    int          latchCnt    = 0;
    int          errCnt      = 0;
    int          errLatchCnt = 0;
    logic [15:0] lastFrame   = '0;
    logic [23:0] pixLog[$];

    int v0, l0, e0, el0, p0;

    // Event recorder, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.pixel_valid) begin
            validCnt++;
            pixLog.push_back(bus.pixel_data);
        end
        if (bus.latch) begin
            latchCnt++;
            lastFrame = bus.frame_pixels;
        end
        if (bus.err) errCnt++;
        if (bus.latch && bus.err) errLatchCnt++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input int hiCycles, input int loCycles);
        bus.DI = 1'b1;
        cyc(hiCycles);
        bus.DI = 1'b0;
        cyc(loCycles);
    endtask

    task automatic sendBit(input logic b);
        if (b) applyStimulus(33, 28);
        else   applyStimulus(18, 43);
    endtask

    task automatic sendPixel(input logic [23:0] v);
        for (int i = 23; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic lowGap(input int n);
        bus.DI = 1'b0;
        cyc(n);
    endtask

    task automatic snap();
        v0  = validCnt;
        l0  = latchCnt;
        e0  = errCnt;
        el0 = errLatchCnt;
        p0  = pixLog.size();
    endtask

    function automatic logic [31:0] pixAt(input int idx);
        if (idx < pixLog.size()) return {8'h00, pixLog[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pixel_valid"},  32'(bus.pixel_valid),  0);
        checkOutput({tag, "_latch"},        32'(bus.latch),        0);
        checkOutput({tag, "_err"},          32'(bus.err),          0);
        checkOutput({tag, "_busy"},         32'(bus.busy),         0);
        checkOutput({tag, "_pixel_data"},   32'(bus.pixel_data),   0);
        checkOutput({tag, "_frame_pixels"}, 32'(bus.frame_pixels), 0);
    endtask

    initial begin
        logic [23:0] tv;
        bus.DI = 1'b0;
        rst_n  = 1'b0;
        cyc(3);
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] single pixel");
        lowGap(2600);
        snap();
        sendPixel(24'hA53CF0);
        lowGap(2500);
        cyc(5);
        checkOutput("t1_valid_cnt",    validCnt - v0, 1);
        checkOutput("t1_pixel",        pixAt(p0), 32'h00A53CF0);
        checkOutput("t1_latch_cnt",    latchCnt - l0, 1);
        checkOutput("t1_frame_pixels", 32'(lastFrame), 1);
        checkOutput("t1_err_cnt",      errCnt - e0, 0);
        checkOutput("t1_pixel_hold",   32'(bus.pixel_data), 32'h00A53CF0);

        $display("[TB] three pixels");
        snap();
        sendPixel(24'hFF0000);
        sendPixel(24'h00FF00);
        sendPixel(24'h0000FF);
        lowGap(2500);
        cyc(5);
        checkOutput("t2_valid_cnt",    validCnt - v0, 3);
        checkOutput("t2_pixel0",       pixAt(p0),     32'h00FF0000);
        checkOutput("t2_pixel1",       pixAt(p0 + 1), 32'h0000FF00);
        checkOutput("t2_pixel2",       pixAt(p0 + 2), 32'h000000FF);
        checkOutput("t2_latch_cnt",    latchCnt - l0, 1);
        checkOutput("t2_frame_pixels", 32'(lastFrame), 3);
        checkOutput("t2_err_cnt",      errCnt - e0, 0);

        $display("[TB] thresholds and glitch");
        tv = 24'h6ABCDE;
        snap();
        applyStimulus(24, 43);
        applyStimulus(25, 43);
        applyStimulus(3, 43);
        cyc(2);
        checkOutput("t3_glitch_err",   errCnt - e0, 1);
        applyStimulus(49, 43);
        cyc(2);
        checkOutput("t3_49_no_err",    errCnt - e0, 1);
        for (int i = 20; i >= 0; i--) sendBit(tv[i]);
        lowGap(2500);
        cyc(5);
        checkOutput("t3_valid_cnt",    validCnt - v0, 1);
        checkOutput("t3_pixel",        pixAt(p0), 32'h006ABCDE);
        checkOutput("t3_frame_pixels", 32'(lastFrame), 1);
        snap();
        applyStimulus(50, 43);
        cyc(2);
        checkOutput("t3_stuck_err",    errCnt - e0, 1);
        sendPixel(24'hFFFFFF);
        lowGap(2600);
        checkOutput("t3_arm_valid",    validCnt - v0, 0);
        checkOutput("t3_arm_latch",    latchCnt - l0, 0);
        checkOutput("t3_arm_err",      errCnt - e0, 1);

        $display("[TB] partial pixel");
        snap();
        for (int i = 0; i < 10; i++) sendBit(i[0]);
        checkOutput("t4_busy",         32'(bus.busy), 1);
        lowGap(2500);
        cyc(5);
        checkOutput("t4_latch_cnt",    latchCnt - l0, 1);
        checkOutput("t4_frame_pixels", 32'(lastFrame), 0);
        checkOutput("t4_err_latch",    errLatchCnt - el0, 1);
        checkOutput("t4_valid_cnt",    validCnt - v0, 0);
        checkOutput("t4_busy_after",   32'(bus.busy), 0);

        $display("[TB] arming and stuck high");
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        snap();
        sendPixel(24'hC3C3C3);
        lowGap(20);
        checkOutput("t5_pre_valid",    validCnt - v0, 0);
        checkOutput("t5_pre_err",      errCnt - e0, 0);
        lowGap(2600);
        checkOutput("t5_arm_latch",    latchCnt - l0, 0);
        snap();
        applyStimulus(200, 43);
        checkOutput("t5_stuck_err",    errCnt - e0, 1);
        sendPixel(24'hFFFFFF);
        cyc(5);
        checkOutput("t5_silent_valid", validCnt - v0, 0);
        checkOutput("t5_silent_err",   errCnt - e0, 1);
        lowGap(2600);
        checkOutput("t5_silent_latch", latchCnt - l0, 0);
        snap();
        sendPixel(24'h123456);
        lowGap(2500);
        cyc(5);
        checkOutput("t5_valid_cnt",    validCnt - v0, 1);
        checkOutput("t5_pixel",        pixAt(p0), 32'h00123456);
        checkOutput("t5_frame_pixels", 32'(lastFrame), 1);

        $display("[TB] reset mid-pixel");
        tv = 24'hABCDEF;
        snap();
        for (int i = 23; i >= 12; i--) sendBit(tv[i]);
        checkOutput("t6_busy_before",  32'(bus.busy), 1);
        rst_n = 1'b0;
        cyc(1);
        checkAllZero("t6_reset");
        rst_n = 1'b1;
        for (int i = 11; i >= 0; i--) sendBit(tv[i]);
        cyc(5);
        checkOutput("t6_ignored_valid", validCnt - v0, 0);
        checkOutput("t6_ignored_err",   errCnt - e0, 0);
        lowGap(2600);
        snap();
        sendPixel(24'h5A5A5A);
        lowGap(2500);
        cyc(5);
        checkOutput("t6_valid_cnt",    validCnt - v0, 1);
        checkOutput("t6_pixel",        pixAt(p0), 32'h005A5A5A);
        checkOutput("t6_latch_cnt",    latchCnt - l0, 1);
        checkOutput("t6_frame_pixels", 32'(lastFrame), 1);
        checkOutput("t6_err_cnt",      errCnt - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
